// File: rtl/imem_pkg.sv
// Shared definitions for the synchronous instruction memory: load/run state
// encoding, default geometry and the word-index width helper.
package imem_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one write port and one registered read port.
// Contents survive reset so a program image persists across resets.
module imem_ram
    import imem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [idx_width(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          re,
    input  logic [idx_width(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]              rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset; clearing a RAM
    // costs a reset mux per bit and would destroy a loaded program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_sync.sv
// Loadable instruction memory: a streaming load port fills the RAM from word 0,
// then byte-addressed fetches return one registered word per cycle.
module inst_mem_sync
    import imem_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_start,
    input  logic                        ld_valid,
    input  logic [WIDTH-1:0]            ld_data,
    input  logic                        ld_last,
    output logic                        ld_ready,
    output logic [idx_width(DEPTH):0]   ld_count,
    input  logic                        req,
    input  logic [WIDTH-1:0]            A,
    output logic [WIDTH-1:0]            RD,
    output logic                        rd_valid,
    output logic                        err,
    output logic                        busy
);

    localparam int IW = idx_width(DEPTH);
    localparam logic [IW-1:0] PTR_ONE = IW'(1);
    localparam logic [IW-1:0] PTR_MAX = IW'(DEPTH - 1);
    localparam logic [IW:0]   CNT_ONE = (IW + 1)'(1);

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW:0]     count_q;
    logic            ld_ready_q;
    logic            busy_q;
    logic            rd_valid_q;
    logic            err_q;

    logic            wr_en;
    logic            fetch_en;
    logic            addr_bad;
    logic [IW-1:0]   fetch_idx;
    logic            rd_valid_d;
    logic            err_d;
    logic [WIDTH-1:0] ram_rdata;

    // ld_start takes priority over both load data and fetches in its cycle.
    assign wr_en     = !rst && (state_q == ST_LOAD) && ld_valid && !ld_start;
    assign fetch_en  = !rst && (state_q == ST_RUN) && req && !ld_start;
    assign fetch_idx = A[IW+1:2];
    assign addr_bad  = (A[1:0] != 2'b00) || ((A >> (IW + 2)) != '0);

    assign rd_valid_d = fetch_en;
    assign err_d      = fetch_en && addr_bad;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            if (ld_start) begin
                state_q    <= ST_LOAD;
                ptr_q      <= '0;
                count_q    <= '0;
                ld_ready_q <= 1'b1;
                busy_q     <= 1'b1;
            end else if (wr_en) begin
                ptr_q   <= ptr_q + PTR_ONE;
                count_q <= count_q + CNT_ONE;
                // The last slot closes the load; ptr wraps but is never used again.
                if (ld_last || (ptr_q == PTR_MAX)) begin
                    state_q    <= ST_RUN;
                    ld_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            end
        end
    end

    imem_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (ptr_q),
        .wdata (ld_data),
        .re    (fetch_en && !addr_bad),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        RD = '0;
        if (rd_valid_q && !err_q) begin
            RD = ram_rdata;
        end
    end

    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign ld_ready = ld_ready_q;
    assign ld_count = count_q;
    assign busy     = busy_q;

endmodule

// File: doc/inst_mem_sync.md
INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning number of words (power of two, >= 2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ld_start  input  1  begin program load at word 0.
REQ-006 The block SHALL have port ld_valid  input  1  ld_data valid this cycle.
REQ-007 The block SHALL have port ld_data  input  WIDTH  instruction word to store.
REQ-008 The block SHALL have port ld_last  input  1  qualifies ld_valid as the final load word.
REQ-009 The block SHALL have port ld_ready  output  1  high only in LOAD.
REQ-010 The block SHALL have port ld_count  output  clog2(DEPTH)+1  words written since last ld_start.
REQ-011 The block SHALL have port req  input  1  fetch request.
REQ-012 The block SHALL have port A  input  WIDTH  byte address of fetch.
REQ-013 The block SHALL have port RD  output  WIDTH  fetched instruction, registered.
REQ-014 The block SHALL have port rd_valid  output  1  RD/err valid this cycle.
REQ-015 The block SHALL have port err  output  1  fetch was misaligned or out of range.
REQ-016 The block SHALL have port busy  output  1  high whenever state is not RUN.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, RUN; IDLE->LOAD on ld_start; LOAD->RUN on accepted ld_valid with ld_last or with ptr = DEPTH-1; RUN->LOAD on ld_start; LOAD->LOAD on ld_start (ptr and ld_count cleared to 0).
REQ-018 In LOAD, ld_valid SHALL write ld_data to mem[ptr], increment ptr and ld_count, in the same edge.
REQ-019 Write at ptr = DEPTH-1 SHALL end the load (no wrap); ld_count then equals DEPTH.
REQ-020 ld_valid outside LOAD, or in the cycle ld_start is high, SHALL be ignored (no write, no count).
REQ-021 In RUN, req SHALL be accepted each cycle (no back-pressure); response appears exactly one cycle later with rd_valid = 1.
REQ-022 Word index SHALL be A[clog2(DEPTH)+1:2]; A[1:0] != 0 or A >= 4*DEPTH SHALL give err = 1, RD = 0.
REQ-023 Valid fetch SHALL give RD = mem[index], err = 0; rd_valid = 0 SHALL force RD = 0, err = 0.
REQ-024 req in IDLE or LOAD, or in the cycle ld_start is high, SHALL be dropped (no response).
REQ-025 Back-to-back reqs SHALL yield back-to-back responses, one per cycle, in order.

Reset
REQ-026 rst SHALL set state IDLE, ptr = 0, ld_count = 0, RD = 0, rd_valid = 0, err = 0, ld_ready = 0, busy = 1.
REQ-027 rst SHALL NOT clear memory contents; rst overrides all other inputs in the same cycle.
REQ-028 rst mid-LOAD SHALL abandon the load; words already written remain.

Structure
REQ-029 State enum, default WIDTH/DEPTH and index-width function SHALL live in shared package imem_pkg.
REQ-030 Storage SHALL be sub-module imem_ram (one write port, one registered read port).

Verification
REQ-031 Reset, ld_start, load 4 words 0x20080005,0x20090003,0x01095020,0xAC0A0000 with ld_last on 4th -> ld_count = 4, busy falls next cycle.
REQ-032 req with A = 4 then A = 12 on consecutive cycles -> rd_valid 2 cycles, RD = 0x20090003 then 0xAC0A0000, err = 0.
REQ-033 req with A = 1 -> next cycle rd_valid = 1, err = 1, RD = 0; req with A = 1024 (DEPTH 256) -> same.
REQ-034 Load DEPTH words without ld_last -> state RUN after word DEPTH, ld_count = 256, extra ld_valid ignored.
REQ-035 req and ld_start same cycle in RUN -> no rd_valid next cycle, ld_ready = 1, ld_count = 0.
REQ-036 rst after 2 of 4 load words -> IDLE, all outputs at reset values; after new load, A = 0 returns new word 0.
